// File: rtl/serial_subtractor_8bit.sv
// Bit-serial 8-bit subtractor: R = A - B, one bit per clock, LSB first, using one
// full-subtractor cell and a single borrow flop, with a start/busy/done handshake.
module serial_subtractor_8bit (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    input  logic A7,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic B4,
    input  logic B5,
    input  logic B6,
    input  logic B7,
    output logic R0,
    output logic R1,
    output logic R2,
    output logic R3,
    output logic R4,
    output logic R5,
    output logic R6,
    output logic R7,
    output logic BORROW,
    output logic ZERO,
    output logic BUSY,
    output logic DONE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0] stateReg;
    logic [1:0] stateNext;
    logic [2:0] bitCntReg;
    logic [7:0] aShiftReg;
    logic [7:0] bShiftReg;
    logic [7:0] diffShiftReg;
    logic       borrowReg;
    logic [7:0] resultReg;
    logic       borrowFlagReg;
    logic       zeroFlagReg;

    logic [7:0] aIn;
    logic [7:0] bIn;
    logic       aBit;
    logic       bBit;
    logic       diffBit;
    logic       borrowNext;
    logic [7:0] diffComplete;
    logic       accept;
    logic       lastBit;

    assign aIn = {A7, A6, A5, A4, A3, A2, A1, A0};
    assign bIn = {B7, B6, B5, B4, B3, B2, B1, B0};

    // Full-subtractor cell operating on the current LSBs and the stored borrow.
    assign aBit       = aShiftReg[0];
    assign bBit       = bShiftReg[0];
    assign diffBit    = aBit ^ bBit ^ borrowReg;
    assign borrowNext = (~aBit & bBit) | (~(aBit ^ bBit) & borrowReg);

    // The final difference includes the bit being produced this cycle.
    assign diffComplete = {diffBit, diffShiftReg[7:1]};

    // start is only honoured outside SHIFT; DONE allows back-to-back launches.
    assign accept  = start && ((stateReg == ST_IDLE) || (stateReg == ST_DONE));
    assign lastBit = (stateReg == ST_SHIFT) && (bitCntReg == 3'd7);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: begin
                if (start) begin
                    stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bitCntReg == 3'd7) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    stateNext = ST_SHIFT;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg      <= ST_IDLE;
            bitCntReg     <= 3'd0;
            aShiftReg     <= 8'd0;
            bShiftReg     <= 8'd0;
            diffShiftReg  <= 8'd0;
            borrowReg     <= 1'b0;
            resultReg     <= 8'd0;
            borrowFlagReg <= 1'b0;
            zeroFlagReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (accept) begin
                aShiftReg    <= aIn;
                bShiftReg    <= bIn;
                diffShiftReg <= 8'd0;
                borrowReg    <= 1'b0;
                bitCntReg    <= 3'd0;
            end else if (stateReg == ST_SHIFT) begin
                aShiftReg    <= {1'b0, aShiftReg[7:1]};
                bShiftReg    <= {1'b0, bShiftReg[7:1]};
                diffShiftReg <= diffComplete;
                borrowReg    <= borrowNext;
                bitCntReg    <= bitCntReg + 3'd1;
            end
            // Visible results change only on completion, never mid-shift.
            if (lastBit) begin
                resultReg     <= diffComplete;
                borrowFlagReg <= borrowNext;
                zeroFlagReg   <= (diffComplete == 8'd0);
            end
        end
    end

    assign R0     = resultReg[0];
    assign R1     = resultReg[1];
    assign R2     = resultReg[2];
    assign R3     = resultReg[3];
    assign R4     = resultReg[4];
    assign R5     = resultReg[5];
    assign R6     = resultReg[6];
    assign R7     = resultReg[7];
    assign BORROW = borrowFlagReg;
    assign ZERO   = zeroFlagReg;
    assign BUSY   = (stateReg == ST_SHIFT);
    assign DONE   = (stateReg == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed bench for serial_subtractor_8bit: hand-computed differences, handshake
// timing, start-during-shift, back-to-back operation and asynchronous reset abort.
module tb_serial_subtractor_8bit;

    logic clk;
    logic rst_n;
    logic start;
    logic A0, A1, A2, A3, A4, A5, A6, A7;
    logic B0, B1, B2, B3, B4, B5, B6, B7;
    logic R0, R1, R2, R3, R4, R5, R6, R7;
    logic BORROW;
    logic ZERO;
    logic BUSY;
    logic DONE;

    int checks;
    int errors;

    serial_subtractor_8bit dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .BORROW(BORROW), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rOut();
        return {R7, R6, R5, R4, R3, R2, R1, R0};
    endfunction

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOperands(input logic [7:0] a, input logic [7:0] b);
        {A7, A6, A5, A4, A3, A2, A1, A0} = a;
        {B7, B6, B5, B4, B3, B2, B1, B0} = b;
    endtask

    // Launch one operation with a start pulse and wait (bounded) for DONE.
    task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                         output int latency, output int busyCnt);
        setOperands(a, b);
        start = 1'b1;
        tick();
        start = 1'b0;
        latency = 0;
        busyCnt = 0;
        while (!DONE && latency < 20) begin
            if (BUSY) busyCnt++;
            tick();
            latency++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] r, input logic brw, input logic zr);
        int lat;
        int busyCnt;
        runOp(a, b, lat, busyCnt);
        check({tag, "_latency"}, 16'(lat), 16'd8);
        check({tag, "_busy_cycles"}, 16'(busyCnt), 16'd8);
        check({tag, "_R"}, {8'd0, rOut()}, {8'd0, r});
        check({tag, "_BORROW"}, {15'd0, BORROW}, {15'd0, brw});
        check({tag, "_ZERO"}, {15'd0, ZERO}, {15'd0, zr});
        $display("op %s: A=%02h B=%02h R=%02h BORROW=%0b ZERO=%0b latency=%0d",
                 tag, a, b, rOut(), BORROW, ZERO, lat);
        tick();
        check({tag, "_done_pulse_end"}, {15'd0, DONE}, 16'd0);
        check({tag, "_idle_busy"}, {15'd0, BUSY}, 16'd0);
    endtask

    initial begin
        int lat;
        int doneCnt;
        bit rStable;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        setOperands(8'h00, 8'h00);
        #2;
        check("reset_R", {8'd0, rOut()}, 16'd0);
        check("reset_flags", {12'd0, BORROW, ZERO, BUSY, DONE}, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        checkResult("05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        checkResult("03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        checkResult("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        checkResult("80-80", 8'h80, 8'h80, 8'h00, 1'b0, 1'b1);
        checkResult("FF-00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

        // start and operand changes during SHIFT must be ignored
        setOperands(8'h05, 8'h03);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        setOperands(8'hAA, 8'h11);
        start = 1'b1;
        tick();
        start = 1'b0;
        setOperands(8'h00, 8'h00);
        check("ignore_R_held", {8'd0, rOut()}, 16'h00FF);
        doneCnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (DONE) doneCnt++;
            tick();
        end
        check("ignore_done_count", 16'(doneCnt), 16'd1);
        check("ignore_R", {8'd0, rOut()}, 16'h0002);
        check("ignore_BORROW", {15'd0, BORROW}, 16'd0);
        $display("op ignore: R=%02h done_pulses=%0d", rOut(), doneCnt);

        // start held high: back-to-back operations
        setOperands(8'h10, 8'h01);
        start = 1'b1;
        tick();
        lat = 0;
        while (!DONE && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_first_latency", 16'(lat), 16'd8);
        check("b2b_first_R", {8'd0, rOut()}, 16'h000F);
        check("b2b_first_BORROW", {15'd0, BORROW}, 16'd0);
        $display("op b2b1: A=10 B=01 R=%02h BORROW=%0b", rOut(), BORROW);
        setOperands(8'h01, 8'h10);
        tick();
        check("b2b_reaccept_busy", {15'd0, BUSY}, 16'd1);
        lat = 1;
        rStable = 1'b1;
        while (!DONE && lat < 20) begin
            if (rOut() !== 8'h0F) rStable = 1'b0;
            tick();
            lat++;
        end
        start = 1'b0;
        check("b2b_spacing", 16'(lat), 16'd9);
        check("b2b_R_stable", {15'd0, rStable}, 16'd1);
        check("b2b_second_R", {8'd0, rOut()}, 16'h00F1);
        check("b2b_second_BORROW", {15'd0, BORROW}, 16'd1);
        $display("op b2b2: A=01 B=10 R=%02h BORROW=%0b spacing=%0d", rOut(), BORROW, lat);
        tick();
        check("b2b_return_idle", {14'd0, BUSY, DONE}, 16'd0);

        // asynchronous reset at bit 4 aborts the operation
        setOperands(8'h37, 8'h12);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_before", {15'd0, BUSY}, 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_R", {8'd0, rOut()}, 16'd0);
        check("abort_flags", {12'd0, BORROW, ZERO, BUSY, DONE}, 16'd0);
        tick();
        rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (DONE || BUSY) doneCnt++;
            tick();
        end
        check("abort_no_done", 16'(doneCnt), 16'd0);
        $display("op abort: outputs cleared, activity_after_release=%0d", doneCnt);
        checkResult("37-12", 8'h37, 8'h12, 8'h25, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
